hazard_stall_ctrl: RTL and testbench

Parametrised hazard and stall controller for the 5-stage RV32I pipeline. It detects load-use hazards and stalls for a configurable number of bubbles, so data memories with longer read latency need no MEM-stage forwarding. It also flushes on EX-stage redirects (taken branch, JAL, JALR) and freezes the whole pipeline while the data memory is not ready. It sits beside the IF/ID and ID/EX pipeline registers and the PC register, drives their enable and flush controls, and keeps stall and flush performance counters.

---
 rtl/hazard_stall_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall / redirect flush / dmem freeze controller for the 5-stage pipeline, zero-cycle comb outputs.
// Freeze dominates and holds everything, including bubble count and redirect acceptance.
module hazard_stall_ctrl #(
   parameter int REG_AW     = 5,
   parameter int LU_BUBBLES = 1,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_ex_memread,
   input  logic [REG_AW-1:0] id_ex_rd,
   input  logic [REG_AW-1:0] if_id_rs1,
   input  logic [REG_AW-1:0] if_id_rs2,
   input  logic              if_id_use_rs1,
   input  logic              if_id_use_rs2,
   input  logic              ex_redirect,
   input  logic              mem_req,
   input  logic              dmem_ready,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              pipe_freeze,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   typedef enum logic {IDLE, LU_STALL} state_t;

   localparam logic [2:0]       BCNT_INIT = 3'(LU_BUBBLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t      state, state_nxt;
   logic [2:0]  bcnt, bcnt_nxt;
   logic        hit, freeze, redirect_acc;

   assign hit = id_ex_memread && (id_ex_rd != '0) &&
                ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                 (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));
   assign freeze = mem_req && !dmem_ready;

   always_comb begin
      state_nxt    = state;
      bcnt_nxt     = bcnt;
      redirect_acc = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      pipe_freeze  = 1'b0;
      if (freeze) begin
         pipe_freeze = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else if (ex_redirect) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         redirect_acc = 1'b1;
         state_nxt    = IDLE;
         bcnt_nxt     = 3'd0;
      end else if (state == LU_STALL) begin
         // Remaining bubbles are committed regardless of the current hit.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
         bcnt_nxt    = bcnt - 3'd1;
         if (bcnt == 3'd1) begin
            state_nxt = IDLE;
         end
      end else if (hit) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
         if (LU_BUBBLES > 1) begin
            state_nxt = LU_STALL;
            bcnt_nxt  = BCNT_INIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bcnt         <= 3'd0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state <= state_nxt;
         bcnt  <= bcnt_nxt;
         if (!pc_write && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
         end
         if (redirect_acc && (flush_count != CNT_MAX)) begin
            flush_count <= flush_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two configurations (3 bubbles / 4-bit counters, 1 bubble / 32-bit counters) share stimulus.
module tb_hazard_stall_ctrl;

   localparam int NB_A = 3;
   localparam int CW_A = 4;
   localparam int NB_B = 1;
   localparam int CW_B = 32;

   typedef struct packed {
      logic        pc_write;
      logic        if_id_write;
      logic        if_id_flush;
      logic        id_ex_flush;
      logic        pipe_freeze;
      logic [31:0] stall_cycles;
      logic [31:0] flush_count;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic id_ex_memread;
   logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
   logic if_id_use_rs1, if_id_use_rs2, ex_redirect, mem_req, dmem_ready;

   logic pw_a, iw_a, iff_a, ef_a, fz_a;
   logic [CW_A-1:0] sc_a, fc_a;
   logic pw_b, iw_b, iff_b, ef_b, fz_b;
   logic [CW_B-1:0] sc_b, fc_b;

   exp_t qa[$];
   exp_t qb[$];
   int vectors = 0;
   int miscompares = 0;
   int cycle_no = 0;

   int rem_a = 0, rem_b = 0;
   logic [31:0] msc_a = 0, mfc_a = 0, msc_b = 0, mfc_b = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_AW(5), .LU_BUBBLES(NB_A), .CNT_W(CW_A)) dut_a (
      .clk(clk), .rst(rst), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1),
      .if_id_use_rs2(if_id_use_rs2), .ex_redirect(ex_redirect), .mem_req(mem_req),
      .dmem_ready(dmem_ready), .pc_write(pw_a), .if_id_write(iw_a), .if_id_flush(iff_a),
      .id_ex_flush(ef_a), .pipe_freeze(fz_a), .stall_cycles(sc_a), .flush_count(fc_a));

   hazard_stall_ctrl #(.REG_AW(5), .LU_BUBBLES(NB_B), .CNT_W(CW_B)) dut_b (
      .clk(clk), .rst(rst), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1),
      .if_id_use_rs2(if_id_use_rs2), .ex_redirect(ex_redirect), .mem_req(mem_req),
      .dmem_ready(dmem_ready), .pc_write(pw_b), .if_id_write(iw_b), .if_id_flush(iff_b),
      .id_ex_flush(ef_b), .pipe_freeze(fz_b), .stall_cycles(sc_b), .flush_count(fc_b));

   // Reference: "rem" = bubbles still owed after the current hazard; freeze never spends one.
   task automatic model_step(input int nb, input int cw, inout int rem,
                             inout logic [31:0] sc, inout logic [31:0] fc, output exp_t e);
      longint cmax;
      logic hit, frz;
      cmax = (longint'(1) << cw) - 1;
      hit = id_ex_memread && (id_ex_rd != 0) &&
            ((if_id_use_rs1 && if_id_rs1 == id_ex_rd) || (if_id_use_rs2 && if_id_rs2 == id_ex_rd));
      frz = mem_req && !dmem_ready;
      e = '0;
      e.stall_cycles = sc;
      e.flush_count  = fc;
      if (frz) begin
         e.pipe_freeze = 1;
      end else if (ex_redirect) begin
         e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1; e.id_ex_flush = 1;
      end else if (rem > 0 || hit) begin
         e.id_ex_flush = 1;
      end else begin
         e.pc_write = 1; e.if_id_write = 1;
      end
      if (rst) begin
         rem = 0; sc = 0; fc = 0;
      end else begin
         if (!e.pc_write && longint'(sc) < cmax) sc = sc + 1;
         if (!frz && ex_redirect && longint'(fc) < cmax) fc = fc + 1;
         if (!frz) begin
            if (ex_redirect) rem = 0;
            else if (rem > 0) rem = rem - 1;
            else if (hit) rem = nb - 1;
         end
      end
   endtask

   task automatic cyc(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input logic u1, input logic u2,
                      input logic redir, input logic mreq, input logic rdy, input logic r);
      exp_t ea, eb;
      @(negedge clk);
      id_ex_memread = mr; id_ex_rd = rd; if_id_rs1 = r1; if_id_rs2 = r2;
      if_id_use_rs1 = u1; if_id_use_rs2 = u2; ex_redirect = redir;
      mem_req = mreq; dmem_ready = rdy; rst = r;
      #1;
      model_step(NB_A, CW_A, rem_a, msc_a, mfc_a, ea);
      model_step(NB_B, CW_B, rem_b, msc_b, mfc_b, eb);
      qa.push_back(ea);
      qb.push_back(eb);
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic report(input string name, input exp_t got, input exp_t e);
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL %s cyc %0d got pw=%b iw=%b iff=%b ef=%b fz=%b sc=%0d fc=%0d exp pw=%b iw=%b iff=%b ef=%b fz=%b sc=%0d fc=%0d",
                  name, cycle_no, got.pc_write, got.if_id_write, got.if_id_flush, got.id_ex_flush,
                  got.pipe_freeze, got.stall_cycles, got.flush_count, e.pc_write, e.if_id_write,
                  e.if_id_flush, e.id_ex_flush, e.pipe_freeze, e.stall_cycles, e.flush_count);
      end
   endtask

   initial begin : monitor
      exp_t ga, gb;
      forever begin
         @(negedge clk);
         #3;
         if (qa.size() > 0 && qb.size() > 0) begin
            cycle_no++;
            ga = '{pw_a, iw_a, iff_a, ef_a, fz_a, 32'(sc_a), 32'(fc_a)};
            gb = '{pw_b, iw_b, iff_b, ef_b, fz_b, sc_b, fc_b};
            report("dut_a", ga, qa.pop_front());
            report("dut_b", gb, qb.pop_front());
         end
      end
   end

   initial begin : driver
      rst = 1; id_ex_memread = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
      if_id_use_rs1 = 0; if_id_use_rs2 = 0; ex_redirect = 0; mem_req = 0; dmem_ready = 1;
      repeat (2) @(negedge clk);
      quiet(2);                                          // post-reset state
      cyc(1, 5, 0, 5, 0, 1, 0, 0, 1, 0); quiet(4);       // load-use on rs2
      cyc(1, 0, 0, 0, 1, 1, 0, 0, 1, 0); quiet(1);       // rd = x0
      cyc(1, 5, 0, 5, 0, 0, 0, 0, 1, 0); quiet(1);       // rs2 unused
      cyc(1, 7, 7, 1, 1, 0, 0, 0, 1, 0);                 // hazard via rs1
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);                 // freeze inside stall x2
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      quiet(4);
      cyc(1, 3, 3, 3, 1, 1, 1, 0, 1, 0); quiet(3);       // redirect beats hazard
      cyc(1, 4, 4, 0, 1, 0, 0, 0, 1, 0);
      cyc(1, 4, 4, 0, 1, 0, 0, 0, 1, 0);                 // in stall, still hazard
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); quiet(3);       // reset mid-stall
      cyc(1, 2, 2, 2, 1, 1, 0, 0, 1, 0);
      cyc(1, 2, 2, 2, 1, 1, 0, 0, 1, 0);
      cyc(1, 2, 2, 2, 1, 1, 0, 0, 1, 0);
      cyc(1, 2, 2, 2, 1, 1, 0, 0, 1, 0); quiet(3);       // back-to-back load-use
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);  // saturation
      quiet(2);
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 6) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 80) == 0));
      end
      quiet(1);
      repeat (3) @(negedge clk);
      vectors++;
      if (qa.size() != 0 || qb.size() != 0) begin
         miscompares++;
         $display("FAIL drain got %0d/%0d pending exp 0", qa.size(), qb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
